// File: rtl/m_ext_pkg.sv
// Shared types and encodings for the RV32 M-extension PCPI controllers and datapaths.
package m_ext_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    HOLD = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/pcpi_mext_decode.sv
// Combinational M-extension decode shared by the multiplier and divider controllers.
module pcpi_mext_decode
  import m_ext_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] insn_i,
  output logic        hit_c,
  output logic        is_mul_c,
  output logic [2:0]  funct3_c
);

  // Register-specifier fields play no part in the decode.
  logic unused_fields;
  assign unused_fields = ^{insn_i[24:15], insn_i[11:7]};

  assign hit_c    = valid_i && (insn_i[6:0] == OPC_OP) && (insn_i[31:25] == F7_MULDIV);
  assign is_mul_c = ~insn_i[14];
  assign funct3_c = insn_i[14:12];

endmodule

// File: rtl/pcpi_mul_ctrl.sv
// PCPI front-end sequencing an external registered multiplier: accept, hold operands
// for MUL_LATENCY edges, return the selected product half with a one-cycle ready.
module pcpi_mul_ctrl
  import m_ext_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcpi_valid,
  input  logic [31:0]        pcpi_insn,
  input  logic [WIDTH-1:0]   pcpi_rs1,
  input  logic [WIDTH-1:0]   pcpi_rs2,
  output logic               pcpi_wr,
  output logic [WIDTH-1:0]   pcpi_rd,
  output logic               pcpi_wait,
  output logic               pcpi_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output mul_op_e            mul_type,
  input  logic [2*WIDTH-1:0] mul_res
);

  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LATENCY - 1);

  logic       dec_hit;
  logic       dec_is_mul;
  logic [2:0] dec_funct3;
  logic       accept_c;
  logic       unused_f3;

  pcpi_mext_decode u_decode (
    .valid_i  (pcpi_valid),
    .insn_i   (pcpi_insn),
    .hit_c    (dec_hit),
    .is_mul_c (dec_is_mul),
    .funct3_c (dec_funct3)
  );

  assign accept_c  = dec_hit & dec_is_mul;
  assign unused_f3 = dec_funct3[2];

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  mul_op_e            type_q, type_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic               wait_q, wait_d;
  logic               ready_q, ready_d;

  // Next-state logic; handshake flops are loaded from the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    type_d  = type_q;
    rd_d    = rd_q;
    wait_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_d     = pcpi_rs1;
          b_d     = pcpi_rs2;
          type_d  = mul_op_e'(dec_funct3[1:0]);
          cnt_d   = '0;
          state_d = BUSY;
          wait_d  = 1'b1;
        end
      end
      BUSY: begin
        // Core withdrawing the request takes priority over a completing product.
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          rd_d    = (type_q == MUL) ? mul_res[WIDTH-1:0] : mul_res[2*WIDTH-1:WIDTH];
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          wait_d = 1'b1;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      type_q  <= MUL;
      rd_q    <= '0;
      wait_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
    end
  end

  assign pcpi_wait  = wait_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_type   = type_q;

endmodule

// File: tb/tb_pcpi_mul_ctrl.sv
// Scoreboard bench for pcpi_mul_ctrl at MUL_LATENCY 1 and 3 against an arithmetic reference.
module tb_pcpi_mul_ctrl;
  import m_ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        valid;
  logic [31:0] insn, rs1, rs2;
  logic        after_hold;
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  logic        wr1, wt1, rdy1, wr3, wt3, rdy3;
  logic [31:0] rd1, a1, b1, rd3, a3, b3;
  logic [1:0]  t1, t3;
  logic [63:0] res1, res3, p3a;

  // Reference full product for each op, from plain signed/unsigned arithmetic.
  function automatic logic [63:0] full_prod(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    case (t)
      2'b01: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      2'b10: begin sp = longint'($signed(a)) * longint'({32'd0, b}); return sp; end
      default: return {32'd0, a} * {32'd0, b};
    endcase
  endfunction

  function automatic logic [31:0] expected(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = full_prod(t, a, b);
    return (t == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Datapaths: combinational for latency 1; two pipeline stages after the operand flops for latency 3.
  assign res1 = full_prod(t1, a1, b1);
  always @(posedge clk) begin
    p3a  <= full_prod(t3, a3, b3);
    res3 <= p3a;
  end

  pcpi_mul_ctrl #(.WIDTH(32), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .pcpi_valid(valid & ~sel), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr1), .pcpi_rd(rd1), .pcpi_wait(wt1),
    .pcpi_ready(rdy1), .mul_a(a1), .mul_b(b1), .mul_type(t1), .mul_res(res1)
  );

  pcpi_mul_ctrl #(.WIDTH(32), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .pcpi_valid(valid & sel), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr3), .pcpi_rd(rd3), .pcpi_wait(wt3),
    .pcpi_ready(rdy3), .mul_a(a3), .mul_b(b3), .mul_type(t3), .mul_res(res3)
  );

  logic        o_wr, o_wt, o_rdy;
  logic [31:0] o_rd, o_a, o_b;
  logic [1:0]  o_t;
  assign o_wr  = sel ? wr3  : wr1;
  assign o_wt  = sel ? wt3  : wt1;
  assign o_rdy = sel ? rdy3 : rdy1;
  assign o_rd  = sel ? rd3  : rd1;
  assign o_a   = sel ? a3   : a1;
  assign o_b   = sel ? b3   : b1;
  assign o_t   = sel ? t3   : t1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (!reset) begin
      chk("wr_tracks_ready", o_wr, o_rdy);
      if (o_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_ready: got rd 0x%0h with no outstanding op", o_rd);
        end else begin
          chk("result", o_rd, exp_q.pop_front());
        end
      end
    end
  end

  // Present one op at the current negedge and check the cycle-exact handshake.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int drop_at, input logic [31:0] exp);
    int lat;
    lat   = sel ? 3 : 1;
    valid = 1'b1;
    insn  = mk_insn(F7_MULDIV, {1'b0, op}, OPC_OP);
    rs1   = a;
    rs2   = b;
    if (drop_at == 0) exp_q.push_back(exp);
    if (after_hold) begin
      @(negedge clk);
      chk("hold_ignores_valid", o_wt, 0);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("wait_busy", o_wt, 1);
      chk("no_early_ready", o_rdy, 0);
      chk("mul_a_stable", o_a, a);
      chk("mul_b_stable", o_b, b);
      chk("mul_type_stable", o_t, op);
      if (drop_at == k) begin
        valid = 1'b0;
        @(negedge clk);
        chk("abort_no_wait", o_wt, 0);
        chk("abort_no_ready", o_rdy, 0);
        after_hold = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("ready_on_time", o_rdy, 1);
    chk("wait_low_done", o_wt, 0);
    @(negedge clk);
    chk("ready_one_cycle", o_rdy, 0);
    chk("wait_low_hold", o_wt, 0);
    after_hold = 1'b1;
  endtask

  task automatic reject(input logic [31:0] w, input int n);
    valid = 1'b1;
    insn  = w;
    rs1   = 32'($urandom);
    rs2   = 32'($urandom);
    repeat (n) begin
      @(negedge clk);
      chk("reject_wait", o_wt, 0);
      chk("reject_ready", o_rdy, 0);
    end
    valid      = 1'b0;
    after_hold = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_wait", o_wt, 0);
    end
    after_hold = 1'b0;
  endtask

  task automatic chk_cleared();
    chk("rst_wait", o_wt, 0);
    chk("rst_ready", o_rdy, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_mul_a", o_a, 0);
    chk("rst_mul_b", o_b, 0);
    chk("rst_mul_type", o_t, 0);
  endtask

  task automatic random_ops(input int n);
    logic [1:0] op;
    logic [31:0] a, b;
    int r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      op = 2'($urandom);
      a  = rnd_opnd();
      b  = rnd_opnd();
      if (r < 6)       issue(op, a, b, 0, expected(op, a, b));
      else if (r == 6) issue(op, a, b, $urandom_range(1, sel ? 3 : 1), 32'd0);
      else if (r == 7) reject(mk_insn(F7_MULDIV, {1'b1, 2'($urandom)}, OPC_OP), $urandom_range(1, 4));
      else             idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; valid = 1'b0; insn = '0; rs1 = '0; rs2 = '0; after_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk_cleared();
    reset = 1'b0;

    issue(MUL, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB);
    issue(MULH, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000);
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);

    reject(mk_insn(F7_MULDIV, 3'b100, OPC_OP), 20);
    reject(mk_insn(7'b0000000, 3'b000, OPC_OP), 20);

    issue(MUL, 32'd9, 32'd9, 1, 32'd0);
    issue(MULHU, 32'hFFFF_FFFF, 32'd2, 0, 32'h0000_0001);

    idle(1);
    valid = 1'b1; insn = mk_insn(F7_MULDIV, 3'b000, OPC_OP); rs1 = 32'd11; rs2 = 32'd13;
    @(negedge clk);
    chk("pre_reset_busy", o_wt, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_cleared();
    @(negedge clk);
    chk("hit_during_reset_ignored", o_wt, 0);
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("no_accept_after_reset", o_wt, 0);
    after_hold = 1'b0;
    issue(MUL, 32'd3, 32'd5, 0, 32'd15);

    random_ops(40);

    idle(2);
    sel = 1'b1;
    issue(MUL, 32'h1234_5678, 32'h0000_0010, 0, 32'h2345_6780);
    issue(MULH, 32'hFFFF_FFFE, 32'h0000_0003, 0, 32'hFFFF_FFFF);
    issue(MULHU, 32'h0000_0005, 32'h0000_0006, 2, 32'd0);
    issue(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'hFFFF_FFFF);
    random_ops(25);

    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
